uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the core's data bus, downstream of the core's `address`/`data_out`/`we` outputs. It decodes a small register window and buffers written bytes in a FIFO. It serialises them 8N1 on `tx` with a programmable baud divisor. Reads return a combinational register value that a top-level mux steers onto the core's `data_in`, so the core needs no stall.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: word-aligned base of the 3-register window.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, minimum 2.
- `DEFAULT_DIV`, 16'd868: baud divisor after reset, in clocks per bit.

Ports:
- `clk`, in, 1: single clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `address`, in, 32: core bus address.
- `data_out`, in, 32: core write data.
- `we`, in, 1: core write enable.
- `sel`, out, 1: `address[31:4]` matches the window. Combinational.
- `rdata`, out, 32: read data for the addressed register. Zero when `sel`=0. Combinational.
- `tx`, out, 1: serial line. Registered; idles high.

## Operation
Registers sit at offsets from `BASE_ADDR`:
- +0 TXDATA (W): a write pushes `data_out[7:0]`. Reads return 0.
- +4 STATUS (R/W1C):
  - bit0: full.
  - bit1: empty.
  - bit2: busy (FSM not IDLE).
  - bit3: overflow (sticky).
  - bits[11:8]: FIFO count.
  - Writing 1 to bit3 clears overflow. Other bits are read-only.
- +8 DIV (R/W): bits[15:0] set the bit period. Written value 0 is stored as 1.
- Offset +C, and any unused bits, read as 0. Writes to them are ignored.

Write decode: the access is decoded when `we`=1 and the address matches. Address bits[1:0] are ignored.

FIFO push rules:
- Push when not full.
- When full and no pop occurs in the same cycle, drop the write and set overflow.
- Push and pop in the same cycle: both occur, and count is unchanged. This applies even when full, so no overflow is raised.

TX FSM, with states IDLE, START, DATA, STOP:
- IDLE: when the FIFO is non-empty, pop into the shift register, load the bit counter with DIV, and go to START.
- START: `tx`=0 for DIV cycles, then go to DATA.
- DATA: send 8 bits LSB first, each for DIV cycles, then go to STOP.
- STOP: `tx`=1 for DIV cycles, then go to IDLE. The FIFO is re-checked on the next cycle.
- Each bit period latches DIV at the start of that bit. A DIV write mid-frame therefore affects the next bit onward.

## Timing
- Reset values:
  - `tx`=1.
  - FSM in IDLE.
  - FIFO empty; count=0.
  - overflow=0.
  - DIV=`DEFAULT_DIV`.
  - `sel`/`rdata` are purely combinational.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronously) and FIFO contents are discarded.
- Latency: a TXDATA write captured at edge N into an empty FIFO while in IDLE gives a pop at edge N+1, with `tx` falling after edge N+1.
- Frame length is 10×DIV cycles. Back-to-back frames are separated by exactly 1 IDLE cycle.
- STATUS read in the same cycle as a push shows the pre-edge state.
- Pointer wrap: pointers are log2(`FIFO_DEPTH`) bits wide. Full/empty are derived from a count of log2(`FIFO_DEPTH`)+1 bits.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for DIV cycles. Frame length becomes 11×DIV.
  - Undefined: no PARITY state; the frame is 8N1.

## Structure
- Shared package `uart_pkg` holds:
  - Register offsets: `UART_TXDATA_OFS`, `UART_STATUS_OFS`, `UART_DIV_OFS`.
  - STATUS bit indices.
  - The FSM state encoding: `tx_state_t`, with `TX_PARITY` guarded by the macro.
- One sub-module, `sync_fifo`:
  - Parameterised width and depth.
  - Push/pop/full/empty/count.
  - Same clock and asynchronous active-low reset.
- The top holds the decode, registers, and FSM.

## Test plan
- Reset, then read STATUS → 32'h0000_0002 (empty); read DIV → 868; `tx`=1.
- DIV=4, write 8'hA5 → `tx` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; busy=1 throughout; 40-cycle frame. With the macro defined, a parity bit 0 follows the data bits and the frame is 44 cycles.
- DIV=1, write 9 bytes back-to-back with no pop (first write while busy) → 8 accepted, the 9th is dropped; STATUS full=1, overflow=1, count=8. Write 32'h8 to STATUS → overflow=0.
- FIFO full while the FSM pops in the same cycle as a TXDATA write → count stays 8, overflow stays 0, the byte is transmitted later in order.
- Write DIV=0, read back → 1.
- Assert `resetn` low mid-DATA → `tx`=1 asynchronously, FIFO empty, DIV back to 868.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Optional parity support is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

   localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
   localparam logic [3:0] UART_STATUS_OFS = 4'h4;
   localparam logic [3:0] UART_DIV_OFS    = 4'h8;

   localparam int STAT_FULL_BIT  = 0;
   localparam int STAT_EMPTY_BIT = 1;
   localparam int STAT_BUSY_BIT  = 2;
   localparam int STAT_OVF_BIT   = 3;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_COUNT_W   = 4;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      TX_PARITY = 3'd4,
`endif
      TX_STOP   = 3'd3
   } tx_state_t;

   // A zero divisor would stall the bit timer, so it is promoted to 1.
   function automatic logic [15:0] div_sanitize(input logic [15:0] v);
      return (v == 16'd0) ? 16'd1 : v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push is accepted when full only if a pop
// happens in the same cycle.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA/STATUS/DIV register window, TX FIFO, 8N1 serialiser.
// Defining UART_TX_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] address,
   input  logic [31:0] data_out,
   input  logic        we,
   output logic        sel,
   output logic [31:0] rdata,
   output logic        tx
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]  reg_ofs;
   logic        wr_txdata, wr_status, wr_div;
   logic        fifo_pop, fifo_full, fifo_empty;
   logic [7:0]  fifo_rdata;
   logic [CW-1:0] fifo_count;
   logic        ovf_q, ovf_d;
   logic [15:0] div_q, div_d;
   logic [31:0] status_w;
   logic        busy;
   logic        unused_ok;

   tx_state_t   state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [15:0] baud_q, baud_d;
   logic        tx_q, tx_d;
   logic        bit_end;

   assign sel       = (address[31:4] == BASE_ADDR[31:4]);
   assign reg_ofs   = {address[3:2], 2'b00};
   assign wr_txdata = we && sel && (reg_ofs == UART_TXDATA_OFS);
   assign wr_status = we && sel && (reg_ofs == UART_STATUS_OFS);
   assign wr_div    = we && sel && (reg_ofs == UART_DIV_OFS);
   assign unused_ok = ^{address[1:0], data_out[31:16]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (wr_txdata),
      .wdata_i (data_out[7:0]),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   always_comb begin
      ovf_d = ovf_q;
      div_d = div_q;
      if (wr_status && data_out[STAT_OVF_BIT]) ovf_d = 1'b0;
      // A write into a full FIFO is only lost when nothing drains in the same cycle.
      if (wr_txdata && fifo_full && !fifo_pop)  ovf_d = 1'b1;
      if (wr_div) div_d = div_sanitize(data_out[15:0]);
   end

   assign busy = (state_q != TX_IDLE);

   always_comb begin
      status_w                 = '0;
      status_w[STAT_FULL_BIT]  = fifo_full;
      status_w[STAT_EMPTY_BIT] = fifo_empty;
      status_w[STAT_BUSY_BIT]  = busy;
      status_w[STAT_OVF_BIT]   = ovf_q;
      status_w[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(fifo_count);
      rdata = '0;
      if (sel) begin
         case (reg_ofs)
            UART_STATUS_OFS: rdata = status_w;
            UART_DIV_OFS:    rdata = {16'h0000, div_q};
            default:         rdata = '0;
         endcase
      end
   end

   assign bit_end = (baud_q == 16'd1);

   // Each bit period reloads the timer from DIV, so a DIV write lands on the next bit.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_idx_d = bit_idx_q;
      baud_d    = baud_q;
      tx_d      = tx_q;
      fifo_pop  = 1'b0;
      case (state_q)
         TX_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shreg_d   = fifo_rdata;
               baud_d    = div_q;
               bit_idx_d = 3'd0;
               tx_d      = 1'b0;
               state_d   = TX_START;
            end
         end
         TX_START: begin
            if (bit_end) begin
               baud_d  = div_q;
               tx_d    = shreg_q[0];
               state_d = TX_DATA;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         TX_DATA: begin
            if (bit_end) begin
               baud_d = div_q;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  tx_d    = ^shreg_q;
                  state_d = TX_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = TX_STOP;
`endif
               end else begin
                  tx_d      = shreg_q[bit_idx_q + 3'd1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         TX_PARITY: begin
            if (bit_end) begin
               baud_d  = div_q;
               tx_d    = 1'b1;
               state_d = TX_STOP;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
`endif
         TX_STOP: begin
            if (bit_end) begin
               state_d = TX_IDLE;
            end else begin
               baud_d = baud_q - 16'd1;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = TX_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= TX_IDLE;
         shreg_q   <= 8'h00;
         bit_idx_q <= 3'd0;
         baud_q    <= 16'd1;
         tx_q      <= 1'b1;
         ovf_q     <= 1'b0;
         div_q     <= DEFAULT_DIV;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_idx_q <= bit_idx_d;
         baud_q    <= baud_d;
         tx_q      <= tx_d;
         ovf_q     <= ovf_d;
         div_q     <= div_d;
      end
   end

   assign tx = tx_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register table, serial-frame scoreboard and multi-cycle corner cases.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

   localparam logic [31:0] A_TX  = 32'h0000_1000;
   localparam logic [31:0] A_ST  = 32'h0000_1004;
   localparam logic [31:0] A_DIV = 32'h0000_1008;
`ifdef UART_TX_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic        clk;
   logic        resetn;
   logic [31:0] address;
   logic [31:0] data_out;
   logic        we;
   logic        sel;
   logic [31:0] rdata;
   logic        tx;

   int          cmp_cnt = 0;
   int          err_cnt = 0;
   int          exp_div = 868;
   bit          mon_en  = 1'b0;
   logic [7:0]  exp_q[$];

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_sel;
      logic [31:0] exp_rdata;
   } vec_t;
   vec_t vecs[$];

   uart_tx_mmio #(
      .BASE_ADDR   (32'h0000_1000),
      .FIFO_DEPTH  (8),
      .DEFAULT_DIV (16'd868)
   ) dut (
      .clk      (clk),
      .resetn   (resetn),
      .address  (address),
      .data_out (data_out),
      .we       (we),
      .sel      (sel),
      .rdata    (rdata),
      .tx       (tx)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      address  = addr;
      data_out = data;
      we       = 1'b1;
   endtask

   task automatic bus_idle();
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      address = addr;
      we      = 1'b0;
      #1;
      check(name, {32'h0, rdata}, {32'h0, exp});
   endtask

   task automatic wait_drain(input string name, input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge clk);
         address = A_ST;
         we      = 1'b0;
         #1;
         if (exp_q.size() == 0 && rdata[2] == 1'b0) done = 1'b1;
      end
      check(name, {63'h0, done}, 64'h1);
   endtask

   // scoreboard: serial monitor, bits sampled in the last cycle of each bit period
   task automatic mon_frame();
      logic [7:0] b;
      int         d;
      d = exp_div;
      b = 8'h00;
      repeat (d - 1) begin
         @(negedge clk);
         if (!mon_en) return;
      end
      check("mon_start_bit", {63'h0, tx}, 64'h0);
      for (int i = 0; i < 8; i++) begin
         repeat (d) begin
            @(negedge clk);
            if (!mon_en) return;
         end
         b[i] = tx;
      end
`ifdef UART_TX_PARITY_EN
      repeat (d) begin
         @(negedge clk);
         if (!mon_en) return;
      end
      check("mon_parity_bit", {63'h0, tx}, {63'h0, ^b});
`endif
      repeat (d) begin
         @(negedge clk);
         if (!mon_en) return;
      end
      check("mon_stop_bit", {63'h0, tx}, 64'h1);
      if (exp_q.size() == 0) begin
         cmp_cnt++;
         err_cnt++;
         $display("FAIL mon_unexpected_frame: got byte %h expected no frame", b);
      end else begin
         check("mon_byte", {56'h0, b}, {56'h0, exp_q.pop_front()});
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && resetn && tx === 1'b0) mon_frame();
      end
   end

   initial begin
      logic [63:0] wave, exp_wave, busy_v, exp_busy;
      logic [7:0]  byte_a5;
      int          bn;
      bit          found;

      resetn   = 1'b0;
      we       = 1'b0;
      address  = 32'h0;
      data_out = 32'h0;
      repeat (3) @(negedge clk);
      check("reset_tx_high", {63'h0, tx}, 64'h1);
      resetn = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;

      // register table: rdata/sel are checked before the edge that commits a write
      vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h0000_0002});
      vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0000_0364});
      vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h0000_100C, 32'h0,         1'b1, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h0000_1006, 32'h0,         1'b1, 32'h0000_0002});
      vecs.push_back('{1'b0, 32'h0000_1010, 32'h0,         1'b0, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'h0000_1008, 32'h0,         1'b1, 32'h0000_0364});
      vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0000_0001});
      vecs.push_back('{1'b1, 32'h0000_100A, 32'hFFFF_2345, 1'b1, 32'h0000_0001});
      vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0000_2345});
      vecs.push_back('{1'b1, 32'h0000_100C, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000});
      vecs.push_back('{1'b1, 32'h0000_1004, 32'hFFFF_FFFF, 1'b1, 32'h0000_0002});
      vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h0000_0002});
      vecs.push_back('{1'b1, 32'h0000_2000, 32'h0000_0007, 1'b0, 32'h0000_0000});
      vecs.push_back('{1'b0, 32'h0000_1004, 32'h0,         1'b1, 32'h0000_0002});
      vecs.push_back('{1'b1, 32'h0000_1008, 32'h0000_0004, 1'b1, 32'h0000_2345});
      vecs.push_back('{1'b0, 32'h0000_1008, 32'h0,         1'b1, 32'h0000_0004});
      foreach (vecs[i]) begin
         @(negedge clk);
         address  = vecs[i].addr;
         data_out = vecs[i].wdata;
         we       = vecs[i].we;
         #1;
         check($sformatf("vec%0d_sel", i), {63'h0, sel}, {63'h0, vecs[i].exp_sel});
         check($sformatf("vec%0d_rdata", i), {32'h0, rdata}, {32'h0, vecs[i].exp_rdata});
      end
      bus_idle();
      exp_div = 4;
      check("idle_tx_after_table", {63'h0, tx}, 64'h1);

      // single frame 0xA5 at DIV=4: full waveform and busy
      byte_a5 = 8'hA5;
      bus_write(A_TX, 32'h0000_00A5);
      exp_q.push_back(byte_a5);
      bus_idle();
      read_check("prepop_status", A_ST, 32'h0000_0100);
      check("prepop_tx_high", {63'h0, tx}, 64'h1);
      wave     = '0;
      busy_v   = '0;
      exp_wave = '0;
      exp_busy = '0;
      for (int i = 0; i <= FB * 4; i++) begin
         @(negedge clk);
         #1;
         wave[i]   = tx;
         busy_v[i] = rdata[2];
         bn = i / 4;
         if (i == FB * 4)        exp_wave[i] = 1'b1;
         else if (bn == 0)       exp_wave[i] = 1'b0;
         else if (bn <= 8)       exp_wave[i] = byte_a5[bn-1];
         else if (bn == FB - 1)  exp_wave[i] = 1'b1;
         else                    exp_wave[i] = ^byte_a5;
         exp_busy[i] = (i < FB * 4);
      end
      check("a5_waveform", wave, exp_wave);
      check("a5_busy", busy_v, exp_busy);
      read_check("a5_idle_status", A_ST, 32'h0000_0002);

      // overflow: FSM busy with a primer while 9 bytes are written
      bus_write(A_TX, 32'h0000_0011);
      exp_q.push_back(8'h11);
      bus_idle();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 9; i++) begin
         bus_write(A_TX, 32'h20 + i);
         if (i < 8) exp_q.push_back(8'(8'h20 + i));
      end
      bus_idle();
      read_check("ovf_status", A_ST, 32'h0000_080D);
      bus_write(A_ST, 32'h0000_0008);
      bus_idle();
      read_check("ovf_cleared", A_ST, 32'h0000_0805);

      // full FIFO: write exactly in the cycle the FSM pops
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         address = A_ST;
         #1;
         if (rdata[2] == 1'b0) found = 1'b1;
      end
      check("pop_window_found", {63'h0, found}, 64'h1);
      if (found) begin
         address  = A_TX;
         data_out = 32'h0000_0099;
         we       = 1'b1;
         exp_q.push_back(8'h99);
         @(negedge clk);
         we = 1'b0;
         read_check("push_pop_full", A_ST, 32'h0000_0805);
      end
      wait_drain("drain_burst", 1000);

      // asynchronous reset in the middle of a data bit
      mon_en = 1'b0;
      bus_write(A_TX, 32'h0000_0000);
      bus_write(A_TX, 32'h0000_0055);
      bus_write(A_TX, 32'h0000_0066);
      bus_idle();
      repeat (6) @(negedge clk);
      read_check("mid_frame_status", A_ST, 32'h0000_0204);
      check("mid_frame_tx_low", {63'h0, tx}, 64'h0);
      #1;
      resetn = 1'b0;
      #1;
      check("async_reset_tx", {63'h0, tx}, 64'h1);
      read_check("reset_status", A_ST, 32'h0000_0002);
      read_check("reset_div", A_DIV, 32'h0000_0364);
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      read_check("post_reset_status", A_ST, 32'h0000_0002);
      check("post_reset_tx", {63'h0, tx}, 64'h1);

      // one more frame at a different divisor
      exp_div = 2;
      bus_write(A_DIV, 32'h0000_0002);
      bus_idle();
      mon_en = 1'b1;
      bus_write(A_TX, 32'h0000_003C);
      exp_q.push_back(8'h3C);
      bus_idle();
      wait_drain("drain_final", 200);
      check("exp_q_empty", 64'(exp_q.size()), 64'h0);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end

endmodule
